// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream bundle for one side of a pipeline-stage register.
// The producer side uses the master modport, the consumer side uses slave.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32'd32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register between core stages: bypass, half-rate latch or
// two-entry skid buffer, with synchronous flush for redirects.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 32'd32,
    parameter int unsigned MODE  = 32'd1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         s,
    pipe_stage_reg_if.master        m,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    if (MODE == 32'd0) begin : g_bypass
        logic unused_s;

        assign unused_s  = clk ^ rst;
        assign m.valid   = s.valid & ~flush;
        assign s.ready   = m.ready | flush;
        assign m.data    = s.data;
        assign occupancy = 2'd0;
    end else begin : g_buffered
        state_e           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             s_ready_q, s_ready_d;
        logic             m_valid_q, m_valid_d;
        logic [1:0]       occ_q, occ_d;
        logic             in_fire_s;
        logic             out_fire_s;

        assign in_fire_s  = s.valid & s_ready_q;
        assign out_fire_s = m_valid_q & m.ready;

        // Next-state and data-path selection; flush overrides any handshake.
        // The half-rate latch never accepts while ONE, so it shares this table.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_fire_s) begin
                            main_d  = s.data;
                            state_d = ST_ONE;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_ONE: begin
                        case ({in_fire_s, out_fire_s})
                            2'b11:   main_d = s.data;
                            2'b10: begin
                                skid_d  = s.data;
                                state_d = ST_TWO;
                            end
                            2'b01:   state_d = ST_EMPTY;
                            default: state_d = ST_ONE;
                        endcase
                    end
                    ST_TWO: begin
                        if (MODE == 32'd1) begin
                            state_d = ST_EMPTY;
                        end else if (out_fire_s) begin
                            main_d  = skid_q;
                            state_d = ST_ONE;
                        end else begin
                            state_d = ST_TWO;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end

        // Handshake flags and occupancy are precomputed so the outputs come
        // straight from flops (no m_ready -> s_ready combinational path).
        always_comb begin
            case (state_d)
                ST_ONE: begin
                    s_ready_d = (MODE != 32'd1);
                    m_valid_d = 1'b1;
                    occ_d     = 2'd1;
                end
                ST_TWO: begin
                    s_ready_d = 1'b0;
                    m_valid_d = 1'b1;
                    occ_d     = 2'd2;
                end
                default: begin
                    s_ready_d = 1'b1;
                    m_valid_d = 1'b0;
                    occ_d     = 2'd0;
                end
            endcase
        end

        // State and payload registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_EMPTY;
                main_q    <= {WIDTH{1'b0}};
                skid_q    <= {WIDTH{1'b0}};
                s_ready_q <= 1'b1;
                m_valid_q <= 1'b0;
                occ_q     <= 2'd0;
            end else begin
                state_q   <= state_d;
                main_q    <= main_d;
                skid_q    <= skid_d;
                s_ready_q <= s_ready_d;
                m_valid_q <= m_valid_d;
                occ_q     <= occ_d;
            end
        end

        assign s.ready   = s_ready_q;
        assign m.valid   = m_valid_q;
        assign m.data    = main_q;
        assign occupancy = occ_q;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: half-rate latch, skid buffer and bypass
// instances exercised one after another on a shared clock and reset.
module tb_pipe_stage_reg;

    logic       clk;
    logic       rst;
    logic       flush1, flush2, flush0;
    logic [1:0] occ1, occ2, occ0;
    int         n_checks;
    int         n_pass;

    pipe_stage_reg_if #(.WIDTH(32)) if_s1 ();
    pipe_stage_reg_if #(.WIDTH(32)) if_m1 ();
    pipe_stage_reg_if #(.WIDTH(32)) if_s2 ();
    pipe_stage_reg_if #(.WIDTH(32)) if_m2 ();
    pipe_stage_reg_if #(.WIDTH(8))  if_s0 ();
    pipe_stage_reg_if #(.WIDTH(8))  if_m0 ();

    pipe_stage_reg #(.WIDTH(32), .MODE(1)) u_half (
        .clk(clk), .rst(rst), .flush(flush1), .s(if_s1), .m(if_m1), .occupancy(occ1)
    );
    pipe_stage_reg #(.WIDTH(32), .MODE(2)) u_skid (
        .clk(clk), .rst(rst), .flush(flush2), .s(if_s2), .m(if_m2), .occupancy(occ2)
    );
    pipe_stage_reg #(.WIDTH(8), .MODE(0)) u_byp (
        .clk(clk), .rst(rst), .flush(flush0), .s(if_s0), .m(if_m0), .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        flush1 = 1'b0; flush2 = 1'b0; flush0 = 1'b0;
        if_s1.valid = 1'b0; if_s1.data = 32'h0; if_m1.ready = 1'b0;
        if_s2.valid = 1'b0; if_s2.data = 32'h0; if_m2.ready = 1'b0;
        if_s0.valid = 1'b0; if_s0.data = 8'h0;  if_m0.ready = 1'b0;

        // Reset state
        cyc(); cyc();
        check("rst_m1_valid", {31'd0, if_m1.valid}, 32'd0);
        check("rst_m1_data",  if_m1.data, 32'd0);
        check("rst_m1_occ",   {30'd0, occ1}, 32'd0);
        check("rst_m2_valid", {31'd0, if_m2.valid}, 32'd0);
        check("rst_m2_occ",   {30'd0, occ2}, 32'd0);
        rst = 1'b0;
        cyc();
        check("post_rst_s1_ready", {31'd0, if_s1.ready}, 32'd1);
        check("post_rst_s2_ready", {31'd0, if_s2.ready}, 32'd1);

        // MODE 1 streaming: output every other cycle
        if_m1.ready = 1'b1; if_s1.valid = 1'b1; if_s1.data = 32'h10;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check($sformatf("h_valid_%0d", k), {31'd0, if_m1.valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("h_ready_%0d", k), {31'd0, if_s1.ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1)
                check($sformatf("h_data_%0d", k), if_m1.data, 32'h10 + 32'((k - 1) / 2));
            if_s1.data = 32'h10 + 32'((k + 1) / 2);
        end
        if_s1.valid = 1'b0; if_m1.ready = 1'b0;

        // MODE 2 streaming: one payload per cycle after one cycle of latency
        if_m2.ready = 1'b1; if_s2.valid = 1'b1; if_s2.data = 32'h10;
        check("s_first_valid_pre", {31'd0, if_m2.valid}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check($sformatf("s_valid_%0d", k), {31'd0, if_m2.valid}, 32'd1);
            check($sformatf("s_data_%0d", k),  if_m2.data, 32'h10 + 32'(k - 1));
            check($sformatf("s_ready_%0d", k), {31'd0, if_s2.ready}, 32'd1);
            check($sformatf("s_occ_%0d", k),   {30'd0, occ2}, 32'd1);
            if_s2.data = 32'h10 + 32'(k);
        end
        if_s2.valid = 1'b0;
        cyc();
        check("s_drain_occ", {30'd0, occ2}, 32'd0);

        // MODE 2 backpressure
        if_s2.valid = 1'b1; if_s2.data = 32'hA0;
        cyc();
        check("bp_first", if_m2.data, 32'hA0);
        if_m2.ready = 1'b0; if_s2.data = 32'hA1;
        cyc();
        if_s2.data = 32'hA2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_occ_%0d", k),   {30'd0, occ2}, 32'd2);
            check($sformatf("bp_ready_%0d", k), {31'd0, if_s2.ready}, 32'd0);
            check($sformatf("bp_hold_%0d", k),  if_m2.data, 32'hA0);
            if (k == 2) if_m2.ready = 1'b1;
            if (k < 2) cyc();
        end
        cyc();
        check("bp_out_a1", if_m2.data, 32'hA1);
        check("bp_ready_back", {31'd0, if_s2.ready}, 32'd1);
        cyc();
        check("bp_out_a2", if_m2.data, 32'hA2);
        if_s2.valid = 1'b0;
        cyc();
        check("bp_empty", {31'd0, if_m2.valid}, 32'd0);

        // MODE 2 flush while full with a payload on offer
        if_m2.ready = 1'b0; if_s2.valid = 1'b1; if_s2.data = 32'hB0;
        cyc();
        if_s2.data = 32'hB1;
        cyc();
        check("fl_occ_full", {30'd0, occ2}, 32'd2);
        if_s2.data = 32'hB5; flush2 = 1'b1;
        cyc();
        check("fl_valid", {31'd0, if_m2.valid}, 32'd0);
        check("fl_occ",   {30'd0, occ2}, 32'd0);
        check("fl_ready", {31'd0, if_s2.ready}, 32'd1);
        flush2 = 1'b0; if_s2.valid = 1'b0; if_m2.ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check($sformatf("fl_no_b5_%0d", k), {31'd0, if_m2.valid}, 32'd0);
        end

        // MODE 1 reset while holding a payload
        if_m1.ready = 1'b0; if_s1.valid = 1'b1; if_s1.data = 32'hDEADBEEF;
        cyc();
        check("rr_full_data", if_m1.data, 32'hDEADBEEF);
        check("rr_full_occ",  {30'd0, occ1}, 32'd1);
        rst = 1'b1; if_s1.valid = 1'b0;
        cyc();
        check("rr_valid", {31'd0, if_m1.valid}, 32'd0);
        check("rr_data",  if_m1.data, 32'd0);
        check("rr_occ",   {30'd0, occ1}, 32'd0);
        rst = 1'b0;
        cyc();
        check("rr_ready", {31'd0, if_s1.ready}, 32'd1);

        // MODE 0 bypass
        if_s0.data = 8'h5A; if_s0.valid = 1'b1; if_m0.ready = 1'b0;
        #1;
        check("by_valid", {31'd0, if_m0.valid}, 32'd1);
        check("by_data",  {24'd0, if_m0.data}, 32'h5A);
        check("by_ready", {31'd0, if_s0.ready}, 32'd0);
        check("by_occ",   {30'd0, occ0}, 32'd0);
        flush0 = 1'b1;
        #1;
        check("by_fl_valid", {31'd0, if_m0.valid}, 32'd0);
        check("by_fl_ready", {31'd0, if_s0.ready}, 32'd1);
        flush0 = 1'b0; if_m0.ready = 1'b1;
        #1;
        check("by_pass_ready", {31'd0, if_s0.ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
